// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types for the ghost AI sequencer and the sprite renderers.
// Holds the aiState codes, the 6-bit timer type and the fright flash threshold.
package ghost_pkg;

    typedef enum logic [3:0] {
        ST_HOUSE   = 4'd0,
        ST_SCATTER = 4'd1,
        ST_CHASE   = 4'd2,
        ST_FRIGHT  = 4'd3,
        ST_EATEN   = 4'd4
    } ai_state_t;

    typedef logic [5:0] timer_t;

    // Renderers flash the frightened sprite once aiTimer drops to this value.
    localparam timer_t FLASH_THRESHOLD = 6'd8;

endpackage

// File: rtl/frame_tick_divider.sv
// frame_tick_divider: turns frame strobes (ce) into one unit tick every
// TICK_FRAMES strobes. Ports: clk, reset (async, high), ce in; tick out.
module frame_tick_divider #(
    parameter int TICK_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    output logic tick
);

    localparam int W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_FRAMES - 1);

    logic [W-1:0] cnt_q;

    // Combinational so the tick lines up with the strobe that completes
    // the unit; the consumer registers everything it derives from it.
    assign tick = ce && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (ce) begin
            if (cnt_q == LAST) cnt_q <= '0;
            else               cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: per-ghost AI mode sequencer (house, scatter/chase
// schedule, fright, eaten return). One instance per ghost, shared ce.
// Ports: clk, reset (async, high), ce, powerPellet, ghostEaten, atHome in;
// aiState[3:0], aiTimer[5:0], reverse out. With GHOST_ELROY_EN defined,
// dotsLeft[7:0] in and elroy out are added.
module ghost_mode_scheduler
    import ghost_pkg::*;
#(
    parameter int TICK_FRAMES  = 8,
    parameter int HOUSE_TIME   = 10,
    parameter int SCATTER_TIME = 7,
    parameter int CHASE_TIME   = 20,
    parameter int FRIGHT_TIME  = 40,
    parameter int LAST_PHASE   = 6
`ifdef GHOST_ELROY_EN
   ,parameter int ELROY_DOTS   = 20
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       powerPellet,
    input  logic       ghostEaten,
    input  logic       atHome,
`ifdef GHOST_ELROY_EN
    input  logic [7:0] dotsLeft,
    output logic       elroy,
`endif
    output logic [3:0] aiState,
    output logic [5:0] aiTimer,
    output logic       reverse
);

    localparam timer_t     T_HOUSE   = timer_t'(HOUSE_TIME);
    localparam timer_t     T_SCATTER = timer_t'(SCATTER_TIME);
    localparam timer_t     T_CHASE   = timer_t'(CHASE_TIME);
    localparam timer_t     T_FRIGHT  = timer_t'(FRIGHT_TIME);
    localparam logic [2:0] P_LAST    = 3'(LAST_PHASE);

    ai_state_t  state_q;
    timer_t     timer_q;
    timer_t     saved_q;
    logic [2:0] phase_q;
    logic       lock_q;
    logic       reverse_q;
    logic       unit_tick;
    logic       elroy_on;

    frame_tick_divider #(
        .TICK_FRAMES(TICK_FRAMES)
    ) u_div (
        .clk  (clk),
        .reset(reset),
        .ce   (ce),
        .tick (unit_tick)
    );

`ifdef GHOST_ELROY_EN
    logic elroy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) elroy_q <= 1'b0;
        else       elroy_q <= (dotsLeft <= 8'(ELROY_DOTS));
    end

    assign elroy    = elroy_q;
    assign elroy_on = elroy_q;
`else
    assign elroy_on = 1'b0;
`endif

    // Mode targets: house exit, next phase, and return from fright.
    // lock_q marks the permanent chase reached after LAST_PHASE.
    ai_state_t  sched_st, next_st, ret_st;
    timer_t     sched_tm, next_tm, ret_tm;
    logic [2:0] phase_nx;

    assign phase_nx = phase_q + 3'd1;

    always_comb begin
        sched_st = ST_SCATTER;
        sched_tm = T_SCATTER;
        if (lock_q) begin
            sched_st = ST_CHASE;
            sched_tm = '0;
        end else if (phase_q[0] || elroy_on) begin
            sched_st = ST_CHASE;
            sched_tm = T_CHASE;
        end

        next_st = ST_SCATTER;
        next_tm = T_SCATTER;
        if (phase_nx[0] || elroy_on) begin
            next_st = ST_CHASE;
            next_tm = T_CHASE;
        end

        ret_st = ST_SCATTER;
        ret_tm = saved_q;
        if (lock_q || phase_q[0]) begin
            ret_st = ST_CHASE;
        end else if (elroy_on) begin
            ret_st = ST_CHASE;
            ret_tm = T_CHASE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HOUSE;
            timer_q   <= T_HOUSE;
            saved_q   <= '0;
            phase_q   <= '0;
            lock_q    <= 1'b0;
            reverse_q <= 1'b0;
        end else begin
            reverse_q <= 1'b0;
            unique case (state_q)
                ST_HOUSE: begin
                    if (unit_tick) begin
                        if (timer_q == '0) begin
                            state_q <= sched_st;
                            timer_q <= sched_tm;
                        end else begin
                            timer_q <= timer_q - 6'd1;
                        end
                    end
                end
                ST_SCATTER, ST_CHASE: begin
                    if (powerPellet) begin
                        saved_q   <= timer_q;
                        state_q   <= ST_FRIGHT;
                        timer_q   <= T_FRIGHT;
                        reverse_q <= ~reverse_q;
                    end else if (unit_tick) begin
                        if (timer_q != '0) begin
                            // Elroy cuts a running scatter short, silently.
                            if (elroy_on && state_q == ST_SCATTER) begin
                                state_q <= ST_CHASE;
                                timer_q <= T_CHASE;
                            end else begin
                                timer_q <= timer_q - 6'd1;
                            end
                        end else if (lock_q) begin
                            timer_q <= '0;
                        end else if (phase_q >= P_LAST) begin
                            lock_q    <= 1'b1;
                            state_q   <= ST_CHASE;
                            timer_q   <= '0;
                            reverse_q <= (state_q == ST_SCATTER)
                                         && !reverse_q;
                        end else begin
                            phase_q   <= phase_nx;
                            state_q   <= next_st;
                            timer_q   <= next_tm;
                            reverse_q <= ~reverse_q;
                        end
                    end
                end
                ST_FRIGHT: begin
                    if (ghostEaten) begin
                        state_q <= ST_EATEN;
                        timer_q <= '0;
                    end else if (powerPellet) begin
                        timer_q <= T_FRIGHT;
                    end else if (unit_tick) begin
                        if (timer_q != '0) begin
                            timer_q <= timer_q - 6'd1;
                        end else begin
                            state_q <= ret_st;
                            timer_q <= ret_tm;
                        end
                    end
                end
                ST_EATEN: begin
                    if (atHome) begin
                        state_q <= ST_HOUSE;
                        timer_q <= T_HOUSE;
                    end
                end
                default: begin
                    state_q <= ST_HOUSE;
                    timer_q <= T_HOUSE;
                end
            endcase
        end
    end

    assign aiState = 4'(state_q);
    assign aiTimer = timer_q;
    assign reverse = reverse_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb_ghost_mode_scheduler: directed bench for the ghost mode sequencer.
// Small parameters; ce pulses once every 4 clks, 2 frames per unit.
module tb_ghost_mode_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       powerPellet = 1'b0;
    logic       ghostEaten = 1'b0;
    logic       atHome = 1'b0;
    logic [3:0] aiState;
    logic [5:0] aiTimer;
    logic       reverse;
`ifdef GHOST_ELROY_EN
    logic [7:0] dotsLeft = 8'd200;
    logic       elroy;
`endif

    int   total = 0;
    int   bad = 0;
    int   rev_cnt = 0;
    logic rev_prev = 1'b0;

    always #5 clk = ~clk;

    ghost_mode_scheduler #(
        .TICK_FRAMES (2),
        .HOUSE_TIME  (2),
        .SCATTER_TIME(3),
        .CHASE_TIME  (4),
        .FRIGHT_TIME (5),
        .LAST_PHASE  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .powerPellet(powerPellet),
        .ghostEaten (ghostEaten),
        .atHome     (atHome),
`ifdef GHOST_ELROY_EN
        .dotsLeft   (dotsLeft),
        .elroy      (elroy),
`endif
        .aiState    (aiState),
        .aiTimer    (aiTimer),
        .reverse    (reverse)
    );

    // Reverse must be a single-clk pulse; count pulses for the tests.
    always @(negedge clk) begin
        if (reverse) begin
            total++;
            if (rev_prev) begin
                bad++;
                $display("FAIL reverse_consecutive: high two clks, want 1");
            end
            rev_cnt++;
        end
        rev_prev = reverse;
    end

    task automatic frame();
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic unit(input int n);
        for (int i = 0; i < n; i++) begin
            frame();
            frame();
        end
    endtask

    task automatic pulse_pellet();
        powerPellet = 1'b1;
        @(negedge clk);
        powerPellet = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (aiState !== 4'd0 || aiTimer !== 6'd2 || reverse !== 1'b0) begin
            bad++;
            $display("FAIL reset: st=%0d tm=%0d rev=%0b want 0/2/0",
                     aiState, aiTimer, reverse);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_house_exit();
        int r0;
        r0 = rev_cnt;
        powerPellet = 1'b1;
        ghostEaten  = 1'b1;
        @(negedge clk);
        powerPellet = 1'b0;
        ghostEaten  = 1'b0;
        total++;
        if (aiState !== 4'd0 || aiTimer !== 6'd2) begin
            bad++;
            $display("FAIL house_ignore: st=%0d tm=%0d want 0/2",
                     aiState, aiTimer);
        end
        for (int i = 0; i < 2; i++) begin
            unit(1);
            total++;
            if (aiState !== 4'd0 || aiTimer !== 6'(1 - i)) begin
                bad++;
                $display("FAIL house_count%0d: st=%0d tm=%0d want 0/%0d",
                         i, aiState, aiTimer, 1 - i);
            end
        end
        unit(1);
        total++;
        if (aiState !== 4'd1 || aiTimer !== 6'd3 || rev_cnt !== r0) begin
            bad++;
            $display("FAIL house_exit: st=%0d tm=%0d revs=%0d want 1/3/%0d",
                     aiState, aiTimer, rev_cnt, r0);
        end
    endtask

    task automatic test_schedule();
        int r0;
        r0 = rev_cnt;
        for (int i = 0; i < 3; i++) begin
            unit(1);
            total++;
            if (aiState !== 4'd1 || aiTimer !== 6'(2 - i)) begin
                bad++;
                $display("FAIL scatter0_%0d: st=%0d tm=%0d want 1/%0d",
                         i, aiState, aiTimer, 2 - i);
            end
        end
        unit(1);
        total++;
        if (aiState !== 4'd2 || aiTimer !== 6'd4 || rev_cnt !== r0 + 1) begin
            bad++;
            $display("FAIL to_chase: st=%0d tm=%0d revs=%0d want 2/4/%0d",
                     aiState, aiTimer, rev_cnt, r0 + 1);
        end
        for (int i = 0; i < 4; i++) begin
            unit(1);
            total++;
            if (aiState !== 4'd2 || aiTimer !== 6'(3 - i)) begin
                bad++;
                $display("FAIL chase1_%0d: st=%0d tm=%0d want 2/%0d",
                         i, aiState, aiTimer, 3 - i);
            end
        end
        unit(1);
        total++;
        if (aiState !== 4'd1 || aiTimer !== 6'd3 || rev_cnt !== r0 + 2) begin
            bad++;
            $display("FAIL to_scatter: st=%0d tm=%0d revs=%0d want 1/3/%0d",
                     aiState, aiTimer, rev_cnt, r0 + 2);
        end
        unit(4);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (aiState !== 4'd2 || aiTimer !== 6'd0) begin
                bad++;
                $display("FAIL chase_hold%0d: st=%0d tm=%0d want 2/0",
                         i, aiState, aiTimer);
            end
            unit(1);
        end
    endtask

    task automatic test_fright();
        int r0;
        do_reset();
        unit(3 + 4 + 2);
        total++;
        if (aiState !== 4'd2 || aiTimer !== 6'd2) begin
            bad++;
            $display("FAIL pre_fright: st=%0d tm=%0d want 2/2",
                     aiState, aiTimer);
        end
        pulse_pellet();
        total++;
        if (aiState !== 4'd3 || aiTimer !== 6'd5 || reverse !== 1'b1) begin
            bad++;
            $display("FAIL fright_enter: st=%0d tm=%0d rev=%0b want 3/5/1",
                     aiState, aiTimer, reverse);
        end
        @(negedge clk);
        total++;
        if (reverse !== 1'b0) begin
            bad++;
            $display("FAIL fright_rev_len: rev=%0b want 0", reverse);
        end
        r0 = rev_cnt;
        for (int i = 0; i < 5; i++) begin
            unit(1);
            total++;
            if (aiState !== 4'd3 || aiTimer !== 6'(4 - i)) begin
                bad++;
                $display("FAIL fright_count%0d: st=%0d tm=%0d want 3/%0d",
                         i, aiState, aiTimer, 4 - i);
            end
        end
        unit(1);
        total++;
        if (aiState !== 4'd2 || aiTimer !== 6'd2 || rev_cnt !== r0) begin
            bad++;
            $display("FAIL fright_exit: st=%0d tm=%0d revs=%0d want 2/2/%0d",
                     aiState, aiTimer, rev_cnt, r0);
        end
    endtask

    task automatic test_pellet_restart();
        pulse_pellet();
        unit(4);
        total++;
        if (aiState !== 4'd3 || aiTimer !== 6'd1) begin
            bad++;
            $display("FAIL restart_pre: st=%0d tm=%0d want 3/1",
                     aiState, aiTimer);
        end
        pulse_pellet();
        total++;
        if (aiState !== 4'd3 || aiTimer !== 6'd5 || reverse !== 1'b0) begin
            bad++;
            $display("FAIL restart: st=%0d tm=%0d rev=%0b want 3/5/0",
                     aiState, aiTimer, reverse);
        end
    endtask

    task automatic test_eaten();
        powerPellet = 1'b1;
        ghostEaten  = 1'b1;
        @(negedge clk);
        powerPellet = 1'b0;
        ghostEaten  = 1'b0;
        total++;
        if (aiState !== 4'd4 || aiTimer !== 6'd0) begin
            bad++;
            $display("FAIL eaten: st=%0d tm=%0d want 4/0", aiState, aiTimer);
        end
        unit(2);
        total++;
        if (aiState !== 4'd4 || aiTimer !== 6'd0) begin
            bad++;
            $display("FAIL eaten_hold: st=%0d tm=%0d want 4/0",
                     aiState, aiTimer);
        end
        atHome = 1'b1;
        @(negedge clk);
        atHome = 1'b0;
        total++;
        if (aiState !== 4'd0 || aiTimer !== 6'd2) begin
            bad++;
            $display("FAIL home: st=%0d tm=%0d want 0/2", aiState, aiTimer);
        end
        // Phase 1 was active, so the house releases straight into chase.
        unit(3);
        total++;
        if (aiState !== 4'd2 || aiTimer !== 6'd4) begin
            bad++;
            $display("FAIL respawn_phase: st=%0d tm=%0d want 2/4",
                     aiState, aiTimer);
        end
    endtask

    task automatic test_async_reset();
        powerPellet = 1'b1;
        @(posedge clk);
        #2;
        powerPellet = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if (aiState !== 4'd0 || aiTimer !== 6'd2 || reverse !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: st=%0d tm=%0d rev=%0b want 0/2/0",
                     aiState, aiTimer, reverse);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef GHOST_ELROY_EN
    task automatic test_elroy();
        do_reset();
        dotsLeft = 8'd21;
        @(negedge clk);
        total++;
        if (elroy !== 1'b0) begin
            bad++;
            $display("FAIL elroy_off: elroy=%0b want 0", elroy);
        end
        dotsLeft = 8'd20;
        @(negedge clk);
        total++;
        if (elroy !== 1'b1) begin
            bad++;
            $display("FAIL elroy_on: elroy=%0b want 1", elroy);
        end
        unit(3);
        total++;
        if (aiState !== 4'd2 || aiTimer !== 6'd4) begin
            bad++;
            $display("FAIL elroy_chase: st=%0d tm=%0d want 2/4",
                     aiState, aiTimer);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_house_exit();
        test_schedule();
        test_fright();
        test_pellet_restart();
        test_eaten();
        test_async_reset();
`ifdef GHOST_ELROY_EN
        test_elroy();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
